// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: captures bytes from the UART receiver rdy/rdy_clr handshake into a
// first-word-fall-through FIFO. Define UART_RX_FIFO_AF_EN to add the registered almost_full output.
//
// state   | meaning
// ST_IDLE | waiting for rx_rdy; a high rx_rdy is captured (written or dropped) at this edge
// ST_ACK  | rx_rdy_clr is high for this single cycle
// ST_WAIT | waiting for the receiver to release rx_rdy before re-arming
module uart_rx_fifo #(
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 12
) (
   input  logic                   clk_50m,
   input  logic                   rst,
   input  logic                   rx_rdy,
   input  logic [7:0]             rx_data,
   output logic                   rx_rdy_clr,
   input  logic                   rd_en,
   output logic [7:0]             dout,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overrun,
   input  logic                   ovr_clr
`ifdef UART_RX_FIFO_AF_EN
   ,
   output logic                   almost_full
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_param_err
      $error("uart_rx_fifo: DEPTH must be a power of two >= 2 and AF_LEVEL within 1..DEPTH");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_WAIT} state_t;

   state_t          state_q, state_d;
   logic [7:0]      mem_q [DEPTH];
   logic [7:0]      mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic            empty_q, empty_d;
   logic            full_q, full_d;
   logic            overrun_q, overrun_d;
   logic            rdy_clr_q, rdy_clr_d;
   logic            capture, pop, wr_ok, drop;
`ifdef UART_RX_FIFO_AF_EN
   localparam logic [AW:0] CNT_AF = (AW+1)'(AF_LEVEL);
   logic            af_q, af_d;
`endif

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rx_rdy) begin
               capture = 1'b1;
               state_d = ST_ACK;
            end
         end
         ST_ACK:  state_d = ST_WAIT;
         ST_WAIT: if (!rx_rdy) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // a pop in the same cycle frees the slot, so a full FIFO still accepts the byte
      pop   = rd_en && !empty_q;
      wr_ok = capture && (!full_q || pop);
      drop  = capture && full_q && !pop;

      mem_d = mem_q;
      if (wr_ok) mem_d[wr_ptr_q] = rx_data;
      wr_ptr_d = wr_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop   ? rd_ptr_q + PTR_ONE : rd_ptr_q;

      count_d = count_q;
      case ({wr_ok, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      empty_d = (count_d == '0);
      full_d  = (count_d == CNT_FULL);

      overrun_d = drop ? 1'b1 : (ovr_clr ? 1'b0 : overrun_q);
      rdy_clr_d = capture;
`ifdef UART_RX_FIFO_AF_EN
      af_d = (count_d >= CNT_AF);
`endif
   end

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
         overrun_q <= 1'b0;
         rdy_clr_q <= 1'b0;
`ifdef UART_RX_FIFO_AF_EN
         af_q      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         empty_q   <= empty_d;
         full_q    <= full_d;
         overrun_q <= overrun_d;
         rdy_clr_q <= rdy_clr_d;
`ifdef UART_RX_FIFO_AF_EN
         af_q      <= af_d;
`endif
      end
   end

   // storage needs no reset: entries are only visible between rd_ptr and wr_ptr
   always_ff @(posedge clk_50m) begin
      mem_q <= mem_d;
   end

   assign rx_rdy_clr = rdy_clr_q;
   assign dout       = mem_q[rd_ptr_q];
   assign empty      = empty_q;
   assign full       = full_q;
   assign count      = count_q;
   assign overrun    = overrun_q;
`ifdef UART_RX_FIFO_AF_EN
   assign almost_full = af_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a protocol-following receiver and random host drive the DUT in
// segments; a queue-based model of the byte buffer predicts every output each cycle.
module tb_uart_rx_fifo;

   localparam int DEPTH    = 16;
   localparam int AF_LEVEL = 12;
   localparam int AW       = $clog2(DEPTH);
   localparam int NSEG     = 18;

   logic          clk_50m = 1'b0;
   logic          rst;
   logic          rx_rdy;
   logic [7:0]    rx_data;
   logic          rx_rdy_clr;
   logic          rd_en;
   logic [7:0]    dout;
   logic          empty;
   logic          full;
   logic [AW:0]   count;
   logic          overrun;
   logic          ovr_clr;
`ifdef UART_RX_FIFO_AF_EN
   logic          almost_full;
`endif

   uart_rx_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
      .clk_50m     (clk_50m),
      .rst         (rst),
      .rx_rdy      (rx_rdy),
      .rx_data     (rx_data),
      .rx_rdy_clr  (rx_rdy_clr),
      .rd_en       (rd_en),
      .dout        (dout),
      .empty       (empty),
      .full        (full),
      .count       (count),
      .overrun     (overrun),
      .ovr_clr     (ovr_clr)
`ifdef UART_RX_FIFO_AF_EN
      ,
      .almost_full (almost_full)
`endif
   );

   always #10 clk_50m = ~clk_50m;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   logic [7:0] mdl_q [$];
   logic       mdl_ovr = 1'b0;
   logic       mdl_clr = 1'b0;

   // receiver / host stimulus state
   logic       new_byte = 1'b0;
   logic       recap    = 1'b0;
   logic       did_rst  = 1'b0;
   int         rphase   = 0;
   int         gap_left = 0;
   int         hold_left = 0;
   int         wait_cnt = 0;
   int         sent     = 0;
   int         seq_val  = 0;

   typedef struct {
      int cycles;
      int limit;
      int data_seq;
      int seq_start;
      int rd_mode;
      int rd_pct;
      int hmin;
      int hmax;
      int gmin;
      int gmax;
      int ovr_pct;
      int rst_bytes;
   } seg_t;

   seg_t segs [NSEG];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // apply this cycle's inputs to the model, advance one clock, compare outputs
   task automatic step();
      logic wr, pp, acc;
      if (rst) begin
         mdl_q.delete();
         mdl_ovr = 1'b0;
         mdl_clr = 1'b0;
      end else begin
         wr  = new_byte;
         pp  = rd_en && (mdl_q.size() > 0);
         acc = wr && ((mdl_q.size() < DEPTH) || pp);
         if (pp) void'(mdl_q.pop_front());
         if (acc) mdl_q.push_back(rx_data);
         if (wr && !acc) mdl_ovr = 1'b1;
         else if (ovr_clr) mdl_ovr = 1'b0;
         mdl_clr = wr;
      end
      @(posedge clk_50m);
      #1;
      chk("rx_rdy_clr", 32'(rx_rdy_clr), 32'(mdl_clr));
      chk("count", 32'(count), 32'(mdl_q.size()));
      chk("empty", 32'(empty), 32'(mdl_q.size() == 0));
      chk("full", 32'(full), 32'(mdl_q.size() == DEPTH));
      chk("overrun", 32'(overrun), 32'(mdl_ovr));
      if (mdl_q.size() > 0) chk("dout", 32'(dout), 32'(mdl_q[0]));
`ifdef UART_RX_FIFO_AF_EN
      chk("almost_full", 32'(almost_full), 32'(mdl_q.size() >= AF_LEVEL));
`endif
   endtask

   // receiver: raise rx_rdy, hold until rx_rdy_clr is seen plus hmin..hmax cycles, drop, gap
   task automatic drive_cycle(input seg_t s);
      new_byte = 1'b0;
      rst      = 1'b0;
      if (recap) begin
         recap    = 1'b0;
         new_byte = 1'b1;
         rphase   = 1;
         wait_cnt = 0;
      end else begin
         case (rphase)
            0: begin
               if (gap_left > 0) gap_left--;
               else if (sent < s.limit) begin
                  rx_rdy   = 1'b1;
                  rx_data  = (s.data_seq != 0) ? 8'(seq_val) : 8'($urandom_range(255, 0));
                  seq_val++;
                  sent++;
                  new_byte = 1'b1;
                  rphase   = 1;
                  wait_cnt = 0;
               end
            end
            1: begin
               if (rx_rdy_clr) begin
                  rphase    = 2;
                  hold_left = int'($urandom_range(s.hmax, s.hmin));
               end else begin
                  wait_cnt++;
                  if (wait_cnt > 4) begin
                     rx_rdy   = 1'b0;
                     rphase   = 0;
                     gap_left = 0;
                  end
               end
            end
            default: begin
               if (s.rst_bytes != 0 && sent == s.rst_bytes && hold_left == 3 && !did_rst) begin
                  rst     = 1'b1;
                  recap   = 1'b1;
                  did_rst = 1'b1;
               end else if (hold_left == 0) begin
                  rx_rdy   = 1'b0;
                  rphase   = 0;
                  gap_left = int'($urandom_range(s.gmax, s.gmin));
               end else begin
                  hold_left--;
               end
            end
         endcase
      end
      rd_en   = (s.rd_mode == 1) ? new_byte : (int'($urandom_range(99, 0)) < s.rd_pct);
      ovr_clr = int'($urandom_range(99, 0)) < s.ovr_pct;
   endtask

   initial begin
      //          cyc  lim  seq start  mode rd%  hmin hmax gmin gmax ovr% rstb
      segs[0]  = '{8,    1,   1, 'hA5,  0,   0,   0,   0,   0,   0,   0,   0};
      segs[1]  = '{6,    0,   0, 0,     0, 100,   0,   0,   0,   0,   0,   0};
      segs[2]  = '{16,   1,   0, 0,     0,   0,   5,   5,   0,   0,   0,   0};
      segs[3]  = '{12,   0,   0, 0,     0, 100,   0,   0,   0,   0,   0,   0};
      segs[4]  = '{80,  17,   1, 'h00,  0,   0,   0,   0,   0,   0,   0,   0};
      segs[5]  = '{30,   0,   0, 0,     0, 100,   0,   0,   0,   0, 100,   0};
      segs[6]  = '{70,  16,   1, 'h40,  0,   0,   0,   0,   0,   0,   0,   0};
      segs[7]  = '{30,   6,   0, 0,     1,   0,   0,   2,   0,   1,   0,   0};
      segs[8]  = '{30,   0,   0, 0,     0, 100,   0,   0,   0,   0, 100,   0};
      for (int i = 9; i < 15; i++)
         segs[i] = '{150, 1000, 0, 0, 0, (i % 2 == 1) ? 10 : 60, 0, 5, 0, 2, 5, 0};
      segs[15] = '{30,   0,   0, 0,     0, 100,   0,   0,   0,   0, 100,   0};
      segs[16] = '{80,   3,   0, 0,     0,   0,   8,   8,   0,   0,   0,   3};
      segs[17] = '{20,   0,   0, 0,     0, 100,   0,   0,   0,   0,   0,   0};

      rst     = 1'b1;
      rx_rdy  = 1'b0;
      rx_data = 8'h00;
      rd_en   = 1'b0;
      ovr_clr = 1'b0;
      step();
      step();
      rst = 1'b0;

      for (int s = 0; s < NSEG; s++) begin
         sent    = 0;
         seq_val = segs[s].seq_start;
         did_rst = 1'b0;
         repeat (segs[s].cycles) begin
            drive_cycle(segs[s]);
            step();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
